// File: rtl/squeeze_layer_if.sv
// Control/address bus between the squeeze-layer sequencer and its MAC array, ifm/wgt memories and ofm writer.
interface squeeze_layer_if #(
  parameter int unsigned IFM_AW = 1,
  parameter int unsigned WGT_AW = 1,
  parameter int unsigned OFM_AW = 1
);
  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic              layer_end;
  logic              ifm_rd;
  logic [IFM_AW-1:0] ifm_addr;
  logic [WGT_AW-1:0] wgt_addr;
  logic              mac_clr;
  logic              mac_en;
  logic              ofm_we;
  logic [OFM_AW-1:0] ofm_addr;

  modport master (
    input  start, stall,
    output busy, done, layer_end, ifm_rd, ifm_addr, wgt_addr, mac_clr, mac_en, ofm_we, ofm_addr
  );

  modport slave (
    output start, stall,
    input  busy, done, layer_end, ifm_rd, ifm_addr, wgt_addr, mac_clr, mac_en, ofm_we, ofm_addr
  );
endinterface

// File: rtl/squeeze_layer_ctrl.sv
// Sequencer for a 1x1 squeeze-conv MAC array: issues ifm/weight reads, MAC clear/enable and ofm writes.
module squeeze_layer_ctrl #(
  parameter int unsigned W_IN    = 32,
  parameter int unsigned H_IN    = 32,
  parameter int unsigned CHIN    = 256,
  parameter int unsigned CHOUT   = 32,
  parameter int unsigned DSP_NO  = 32,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  squeeze_layer_if.master   bus
);

  localparam int unsigned PIX    = W_IN * H_IN;
  localparam int unsigned GROUPS = CHOUT / DSP_NO;
  localparam int unsigned IFM_AW = (PIX * CHIN > 1)    ? $clog2(PIX * CHIN)    : 1;
  localparam int unsigned WGT_AW = (GROUPS * CHIN > 1) ? $clog2(GROUPS * CHIN) : 1;
  localparam int unsigned OFM_AW = (PIX * GROUPS > 1)  ? $clog2(PIX * GROUPS)  : 1;
  localparam int unsigned CH_W   = (CHIN > 1)   ? $clog2(CHIN)   : 1;
  localparam int unsigned PIX_W  = (PIX > 1)    ? $clog2(PIX)    : 1;
  localparam int unsigned GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned PIPE_D = MEM_LAT + MAC_LAT + 1;
  localparam logic [OFM_AW-1:0] OFM_LAST = OFM_AW'(PIX * GROUPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Per-issue tag travelling down the memory/MAC latency pipeline.
  typedef struct packed {
    logic              valid;
    logic              first;
    logic              last;
    logic [OFM_AW-1:0] oaddr;
  } tag_t;

  state_t state_q, state_d;
  logic   stall;
  logic   issue_c, finish_c, final_we_c;
  logic   ch_last_c, pix_last_c, grp_last_c, item_last_c;

  logic [CH_W-1:0]   ch_q;
  logic [PIX_W-1:0]  pix_q;
  logic [GRP_W-1:0]  grp_q;
  logic [IFM_AW-1:0] ifm_cnt_q;
  logic [WGT_AW-1:0] wgt_base_q;
  logic [OFM_AW-1:0] ofm_cnt_q;

  logic              busy_q, done_q, layer_end_q, ifm_rd_q;
  logic [IFM_AW-1:0] ifm_addr_q;
  logic [WGT_AW-1:0] wgt_addr_q;
  tag_t              pipe_q [PIPE_D];

  assign stall       = bus.stall;
  assign ch_last_c   = (ch_q == CH_W'(CHIN - 1));
  assign pix_last_c  = (pix_q == PIX_W'(PIX - 1));
  assign grp_last_c  = (grp_q == GRP_W'(GROUPS - 1));
  assign item_last_c = ch_last_c & pix_last_c & grp_last_c;
  assign final_we_c  = pipe_q[PIPE_D-1].valid & pipe_q[PIPE_D-1].last &
                       (pipe_q[PIPE_D-1].oaddr == OFM_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state plus issue/finish decisions; nothing moves while stalled.
  always_comb begin
    state_d  = state_q;
    issue_c  = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !stall) begin
          issue_c = 1'b1;
          state_d = item_last_c ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          issue_c = 1'b1;
          if (item_last_c) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!stall && final_we_c) begin
          finish_c = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, issue registers, latency pipeline and status flags; all frozen by stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q        <= '0;
      pix_q       <= '0;
      grp_q       <= '0;
      ifm_cnt_q   <= '0;
      wgt_base_q  <= '0;
      ofm_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      layer_end_q <= 1'b0;
      ifm_rd_q    <= 1'b0;
      ifm_addr_q  <= '0;
      wgt_addr_q  <= '0;
      for (int i = 0; i < PIPE_D; i++) pipe_q[i] <= '0;
    end else if (!stall) begin
      done_q   <= finish_c;
      ifm_rd_q <= issue_c;
      for (int i = PIPE_D - 1; i > 0; i--) pipe_q[i] <= pipe_q[i-1];
      pipe_q[0] <= '0;
      if (finish_c) begin
        busy_q      <= 1'b0;
        layer_end_q <= 1'b1;
      end
      if (issue_c) begin
        if (state_q == IDLE) begin
          busy_q      <= 1'b1;
          layer_end_q <= 1'b0;
        end
        ifm_addr_q <= ifm_cnt_q;
        wgt_addr_q <= wgt_base_q + WGT_AW'(ch_q);
        pipe_q[0]  <= '{valid: 1'b1, first: (ch_q == '0), last: ch_last_c, oaddr: ofm_cnt_q};
        ch_q       <= ch_last_c ? '0 : ch_q + CH_W'(1);
        ifm_cnt_q  <= (ch_last_c && pix_last_c) ? '0 : ifm_cnt_q + IFM_AW'(1);
        if (ch_last_c) begin
          ofm_cnt_q <= item_last_c ? '0 : ofm_cnt_q + OFM_AW'(1);
          pix_q     <= pix_last_c ? '0 : pix_q + PIX_W'(1);
          if (pix_last_c) begin
            grp_q      <= grp_last_c ? '0 : grp_q + GRP_W'(1);
            wgt_base_q <= grp_last_c ? '0 : wgt_base_q + WGT_AW'(CHIN);
          end
        end
      end
    end
  end

  // Strobes are masked during stall so each item is seen exactly once downstream.
  assign bus.busy      = busy_q;
  assign bus.layer_end = layer_end_q;
  assign bus.done      = done_q & ~stall;
  assign bus.ifm_rd    = ifm_rd_q & ~stall;
  assign bus.ifm_addr  = ifm_addr_q;
  assign bus.wgt_addr  = wgt_addr_q;
  assign bus.mac_en    = pipe_q[MEM_LAT].valid & ~stall;
  assign bus.mac_clr   = pipe_q[MEM_LAT].valid & pipe_q[MEM_LAT].first & ~stall;
  assign bus.ofm_we    = pipe_q[PIPE_D-1].valid & pipe_q[PIPE_D-1].last & ~stall;
  assign bus.ofm_addr  = pipe_q[PIPE_D-1].oaddr;

endmodule
